// File: rtl/verinject_pkg.sv
// Shared constants for the injection scheduler: injector codes, FSM encoding, reserved-code check.
// No logic of its own; all latency and flow control live in the modules that import it.
package verinject_pkg;

    localparam logic [31:0] INJ_IDLE  = 32'hFFFF_FFFF;
    localparam logic [31:0] INJ_CLEAR = 32'hFFFF_FFFE;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // The two top codes are commands to the injectors, never fault bit indices.
    function automatic logic is_reserved(input logic [31:0] bit_idx);
        return bit_idx >= INJ_CLEAR;
    endfunction

endpackage

// File: rtl/verinject_sched_table.sv
// Schedule entry storage with load qualification; writes land one edge after load_valid.
// No backpressure: a rejected load is dropped and flagged by a one-cycle load_err pulse.
module verinject_sched_table
    import verinject_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CYCLE_W = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     load_valid,
    input  logic                     load_allowed,
    input  logic [$clog2(DEPTH)-1:0] load_index,
    input  logic [CYCLE_W-1:0]       load_cycle,
    input  logic [31:0]              load_bit,
    input  logic [$clog2(DEPTH)-1:0] rd_index,
    output logic [CYCLE_W-1:0]       rd_cycle,
    output logic [31:0]              rd_bit,
    output logic                     load_err
);

    logic [CYCLE_W-1:0] r_cycle [DEPTH];
    logic [31:0]        r_bit   [DEPTH];
    logic               r_load_err;
    logic               w_accept;

    assign w_accept = load_valid && load_allowed && !is_reserved(load_bit);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cycle[i] <= '0;
                r_bit[i]   <= INJ_IDLE;
            end
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= load_valid && !w_accept;
            if (w_accept) begin
                r_cycle[load_index] <= load_cycle;
                r_bit[load_index]   <= load_bit;
            end
        end
    end

    assign rd_cycle = r_cycle[rd_index];
    assign rd_bit   = r_bit[rd_index];
    assign load_err = r_load_err;

endmodule

// File: rtl/verinject_injection_scheduler.sv
// Fires scheduled fault-bit codes onto the injector bus; entry N appears after edge E+1+N (E+2+N with
// VERINJECT_SCHED_CLEAR_ON_START_EN). No backpressure: loads outside IDLE/DONE are dropped, start ignored while busy.
module verinject_injection_scheduler
    import verinject_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CYCLE_W = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     load_valid,
    input  logic [$clog2(DEPTH)-1:0] load_index,
    input  logic [CYCLE_W-1:0]       load_cycle,
    input  logic [31:0]              load_bit,
    output logic                     load_err,
    input  logic [$clog2(DEPTH):0]   entry_count,
    input  logic                     start,
    input  logic                     abort,
    output logic [31:0]              verinject__injector_state,
    output logic                     busy,
    output logic                     done,
    output logic                     late,
    output logic [$clog2(DEPTH):0]   fired_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [1:0]         r_state;
    logic [CYCLE_W-1:0] r_counter;
    logic [CNT_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_fired;
    logic               r_late;
    logic [31:0]        r_inj;

    logic               w_idle_or_done;
    logic [CNT_W-1:0]   w_count_clamped;
    logic [CYCLE_W-1:0] w_ent_cycle;
    logic [31:0]        w_ent_bit;

    assign w_idle_or_done  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_count_clamped = (entry_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : entry_count;

    verinject_sched_table #(
        .DEPTH   (DEPTH),
        .CYCLE_W (CYCLE_W)
    ) u_table (
        .clock        (clock),
        .reset_n      (reset_n),
        .load_valid   (load_valid),
        .load_allowed (w_idle_or_done),
        .load_index   (load_index),
        .load_cycle   (load_cycle),
        .load_bit     (load_bit),
        .rd_index     (r_ptr[IDX_W-1:0]),
        .rd_cycle     (w_ent_cycle),
        .rd_bit       (w_ent_bit),
        .load_err     (load_err)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_counter <= '0;
            r_ptr     <= '0;
            r_count   <= '0;
            r_fired   <= '0;
            r_late    <= 1'b0;
            r_inj     <= INJ_IDLE;
        end else begin
            r_inj <= INJ_IDLE;
            if (abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            r_count   <= w_count_clamped;
                            r_fired   <= '0;
                            r_late    <= 1'b0;
                            r_ptr     <= '0;
                            r_counter <= '0;
`ifdef VERINJECT_SCHED_CLEAR_ON_START_EN
                            r_state   <= ST_CLEAR;
`else
                            r_state   <= (w_count_clamped == '0) ? ST_DONE : ST_RUN;
`endif
                        end
                    end
                    ST_CLEAR: begin
                        r_inj     <= INJ_CLEAR;
                        r_counter <= '0;
                        r_state   <= (r_count == '0) ? ST_DONE : ST_RUN;
                    end
                    ST_RUN: begin
                        // Pointer reaching the count means the last fire has already been presented.
                        if (r_ptr == r_count) begin
                            r_state <= ST_DONE;
                        end else if (w_ent_cycle <= r_counter) begin
                            r_inj   <= w_ent_bit;
                            r_ptr   <= r_ptr + CNT_W'(1);
                            r_fired <= r_fired + CNT_W'(1);
                            if (w_ent_cycle < r_counter)
                                r_late <= 1'b1;
                        end
                        if (r_counter != '1)
                            r_counter <= r_counter + CYCLE_W'(1);
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign verinject__injector_state = r_inj;
    assign busy        = (r_state == ST_CLEAR) || (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign late        = r_late;
    assign fired_count = r_fired;

endmodule

// File: tb/tb_verinject_injection_scheduler.sv
// Directed bench for the injection scheduler; expected timings are hand-derived from start edge E.
module tb_verinject_injection_scheduler;
`ifdef VERINJECT_SCHED_CLEAR_ON_START_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        load_valid = 1'b0;
    logic [2:0]  load_index = '0;
    logic [31:0] load_cycle = '0;
    logic [31:0] load_bit = '0;
    logic        load_err;
    logic [3:0]  entry_count = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] inj;
    logic        busy;
    logic        done;
    logic        late;
    logic [3:0]  fired_count;

    int n_checks = 0;
    int n_errors = 0;

    verinject_injection_scheduler #(
        .DEPTH   (8),
        .CYCLE_W (32)
    ) dut (
        .clock                     (clock),
        .reset_n                   (reset_n),
        .load_valid                (load_valid),
        .load_index                (load_index),
        .load_cycle                (load_cycle),
        .load_bit                  (load_bit),
        .load_err                  (load_err),
        .entry_count               (entry_count),
        .start                     (start),
        .abort                     (abort),
        .verinject__injector_state (inj),
        .busy                      (busy),
        .done                      (done),
        .late                      (late),
        .fired_count               (fired_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_entry(input logic [2:0] idx, input logic [31:0] cyc, input logic [31:0] bt);
        load_valid = 1'b1;
        load_index = idx;
        load_cycle = cyc;
        load_bit   = bt;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic go(input logic [3:0] cnt);
        entry_count = cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_inj;

        #1 reset_n = 1'b0;
        #2;
        chk("rst_inj", inj, 32'hFFFF_FFFF);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_late", late, 0);
        chk("rst_fired", fired_count, 0);
        chk("rst_lderr", load_err, 0);
        #4 reset_n = 1'b1;
        tick();

        // Two ordered entries, on-time fires
        load_entry(3'd0, 32'd3, 32'd100);
        chk("ld0_err", load_err, 0);
        load_entry(3'd1, 32'd5, 32'd7);
        chk("ld1_err", load_err, 0);
        go(4'd2);
        chk("a_busy", busy, 1);
        for (int k = 1; k <= 8 + OFF; k++) begin
            tick();
            if (k == 4 + OFF)           exp_inj = 32'd100;
            else if (k == 6 + OFF)      exp_inj = 32'd7;
            else if (OFF == 1 && k == 1) exp_inj = 32'hFFFF_FFFE;
            else                        exp_inj = 32'hFFFF_FFFF;
            chk($sformatf("a_inj_k%0d", k), inj, exp_inj);
        end
        chk("a_done", done, 1);
        chk("a_busy_end", busy, 0);
        chk("a_fired", fired_count, 2);
        chk("a_late", late, 0);

        // Reserved codes rejected in DONE
        load_entry(3'd0, 32'd1, 32'hFFFF_FFFE);
        chk("resv_fe_err", load_err, 1);
        load_entry(3'd0, 32'd1, 32'hFFFF_FFFF);
        chk("resv_ff_err", load_err, 1);
        tick();
        chk("resv_err_clr", load_err, 0);

        // Rerun: load during run dropped, start while busy ignored, abort after first fire
        go(4'd2);
        for (int k = 1; k <= 8 + OFF; k++) begin
            if (k == 1) begin
                load_valid = 1'b1; load_index = 3'd0; load_cycle = 32'd0; load_bit = 32'd55;
            end
            if (k == 2) begin
                start = 1'b1; entry_count = 4'd1;
            end
            if (k == 5 + OFF) abort = 1'b1;
            tick();
            load_valid = 1'b0; start = 1'b0; abort = 1'b0;
            if (k == 1) chk("run_ld_err", load_err, 1);
            if (k == 2) chk("run_ld_err_clr", load_err, 0);
            if (k == 4 + OFF) chk("b_inj_first", inj, 32'd100);
            if (k == 5 + OFF) begin
                chk("ab_inj", inj, 32'hFFFF_FFFF);
                chk("ab_busy", busy, 0);
                chk("ab_done", done, 0);
                chk("ab_fired", fired_count, 1);
                break;
            end
        end

        // Abort beats start
        entry_count = 4'd2; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abst_busy", busy, 0);
        chk("abst_done", done, 0);

        // Equal cycles fire back to back and flag late
        load_entry(3'd0, 32'd2, 32'd9);
        load_entry(3'd1, 32'd2, 32'd10);
        go(4'd2);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 3 + OFF)           exp_inj = 32'd9;
            else if (k == 4 + OFF)      exp_inj = 32'd10;
            else if (OFF == 1 && k == 1) exp_inj = 32'hFFFF_FFFE;
            else                        exp_inj = 32'hFFFF_FFFF;
            chk($sformatf("c_inj_k%0d", k), inj, exp_inj);
        end
        chk("c_late", late, 1);
        chk("c_fired", fired_count, 2);
        chk("c_done", done, 1);

        // Zero entries
        go(4'd0);
        repeat (OFF) tick();
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        chk("z_fired", fired_count, 0);
        chk("z_late", late, 0);

        // Asynchronous reset mid-run
        go(4'd2);
        repeat (3 + OFF) tick();
        chk("d_inj_pre", inj, 32'd9);
        #2 reset_n = 1'b0;
        #1;
        chk("d_rst_inj", inj, 32'hFFFF_FFFF);
        chk("d_rst_busy", busy, 0);
        chk("d_rst_done", done, 0);
        chk("d_rst_fired", fired_count, 0);
        chk("d_rst_late", late, 0);
        #1 reset_n = 1'b1;
        tick();

        // Cleared table: cycle-0 entries fire back to back with the idle code
        go(4'd2);
        repeat (2 + OFF) tick();
        chk("e_inj", inj, 32'hFFFF_FFFF);
        chk("e_fired", fired_count, 2);
        chk("e_late", late, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/verinject_injection_scheduler.md
VERINJECT_INJECTION_SCHEDULER -- requirements
Module: verinject_injection_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of schedule entries (power of two, 2..64).
REQ-002 SHALL have parameter CYCLE_W, default 32, width of the cycle counter and of entry cycle fields.
REQ-003 SHALL have ports: clock in 1, single clock. reset_n in 1, asynchronous, active-low reset.
REQ-004 SHALL have ports: load_valid in 1, table write strobe. load_index in $clog2(DEPTH), entry slot. load_cycle in CYCLE_W, fire cycle. load_bit in 32, flat fault bit index.
REQ-005 SHALL have ports: load_err out 1, one-cycle pulse when a load is rejected.
REQ-006 SHALL have ports: entry_count in $clog2(DEPTH)+1, number of entries to run, sampled on start. start in 1, begin schedule. abort in 1, stop schedule.
REQ-007 SHALL have ports: verinject__injector_state out 32, drives every injector in the design. busy out 1. done out 1. late out 1, sticky. fired_count out $clog2(DEPTH)+1.

Function
REQ-008 SHALL implement states IDLE, CLEAR, RUN, DONE.
REQ-009 SHALL register verinject__injector_state; value 32'hFFFF_FFFF (no injection) in every cycle except fire and clear cycles.
REQ-010 SHALL accept loads only in IDLE or DONE; loads in CLEAR/RUN are dropped with load_err.
REQ-011 SHALL reject loads with load_bit >= 32'hFFFF_FFFE (reserved codes) with load_err; the table is unchanged.
REQ-012 SHALL, on start in IDLE or DONE, latch min(entry_count, DEPTH), clear fired_count and late, and go to CLEAR if macro enabled, otherwise RUN.
REQ-013 SHALL, in CLEAR, drive 32'hFFFF_FFFE for exactly one cycle and then enter RUN.
REQ-014 SHALL, in RUN, increment the cycle counter from 0 each cycle, saturating at all-ones.
REQ-015 SHALL fire entries in index order, at most one per cycle: entry ptr fires when its cycle <= counter; verinject__injector_state = load_bit for one cycle.
REQ-016 SHALL time fires so that, with start sampled at edge E, an entry with cycle N is presented during the cycle after edge E+1+N (E+2+N with CLEAR).
REQ-017 SHALL set late when an entry fires after its nominal cycle (non-monotonic or equal cycles); late holds until the next start.
REQ-018 SHALL increment fired_count per fire, and go to DONE after the last entry's fire cycle; entry_count 0 goes straight to DONE after CLEAR/start.
REQ-019 SHALL hold busy high in CLEAR and RUN only; done high in DONE only.
REQ-020 SHALL, on abort in any state, enter IDLE next edge with verinject__injector_state 32'hFFFF_FFFF; abort beats a simultaneous start.
REQ-021 SHALL ignore start while busy.

Reset
REQ-022 SHALL, on reset_n low, asynchronously enter IDLE: verinject__injector_state 32'hFFFF_FFFF, busy 0, done 0, late 0, fired_count 0, load_err 0, counter 0.
REQ-023 SHALL clear all table entries to cycle 0, bit 32'hFFFF_FFFF on reset.

Configuration
REQ-024 SHALL support macro VERINJECT_SCHED_CLEAR_ON_START_EN: defined, every start passes through CLEAR; undefined, CLEAR is unreachable and start goes directly to RUN.

Structure
REQ-025 SHALL take 32'hFFFF_FFFF (idle), 32'hFFFF_FFFE (clear), and the state encoding from shared package verinject_pkg.
REQ-026 SHALL place the entry storage and load checks in sub-module verinject_sched_table.

Verification
REQ-027 SHALL cover: entries {(3, 100), (5, 7)}, count 2, macro off -> 100 after edge E+4, 7 after E+6, done, fired_count 2, late 0.
REQ-028 SHALL cover: macro on, same load -> 32'hFFFF_FFFE after E+1, 100 after E+5.
REQ-029 SHALL cover: entries {(2, 9), (2, 10)} -> 9 and 10 on consecutive cycles, late 1.
REQ-030 SHALL cover: abort during RUN before the second fire -> IDLE, output 32'hFFFF_FFFF, fired_count 1.
REQ-031 SHALL cover: load_bit 32'hFFFF_FFFE, or any load during RUN -> load_err pulse, table unchanged.
REQ-032 SHALL cover: reset_n asserted mid-RUN -> all outputs at reset values without waiting for a clock edge.
